// File: rtl/light_seq_ctrl_pkg.sv
// Purpose: shared state encoding and thermometer helper for the lamp sequencer.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package light_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2,
    ST_HAZ   = 2'd3
  } state_t;

  // Thermometer code with the n lowest bits set; callers cast down to their bank width.
  function automatic logic [31:0] thermo(input int n);
    if (n <= 0)  return 32'd0;
    if (n >= 32) return '1;
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/light_seq_ctrl_tick_gen.sv
// Purpose: step prescaler; o_tick every DIV_MAX+1 enabled cycles.
// Latency: o_tick is combinational from the counter; clear takes effect next clk.
// Backpressure: none; i_clr overrides i_en.
//
// Ports:
//   clk    in  1  clock, rising edge
//   reset  in  1  asynchronous, active-high
//   i_clr  in  1  force counter to 0 on the next edge
//   i_en   in  1  count enable; tick only asserted while enabled
//   o_tick out 1  terminal count reached this cycle
module tick_gen #(
  parameter int DIV_W   = 24,
  parameter int DIV_MAX = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  if (DIV_W < 1 || DIV_W > 62 || DIV_MAX < 0 ||
      longint'(DIV_MAX) > ((longint'(1) << DIV_W) - longint'(1))) begin : g_bad_div
    $error("tick_gen: DIV_MAX does not fit in DIV_W bits");
  end

  localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV_MAX);

  logic [DIV_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = i_en && (r_cnt == TERM);
  assign o_tick = w_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/light_seq_ctrl.sv
// Purpose: thermometer lamp sequencer for left/right sweeps and hazard blink.
// Latency: request accepted 1 clk after it is seen in IDLE; all outputs registered.
// Backpressure: none; requests are levels, opposite direction during a sweep is dropped.
//
// Ports:
//   clk         in  1      clock, rising edge
//   reset       in  1      asynchronous, active-high
//   left_req    in  1      left sweep request (level)
//   right_req   in  1      right sweep request (level)
//   hazard_req  in  1      hazard blink request (level)
//   lamp_l      out WIDTH  left bank, bit0 innermost
//   lamp_r      out WIDTH  right bank, bit0 innermost
//   busy        out 1      sequence in progress
//   done        out 1      one-clk pulse on return to IDLE
module light_seq_ctrl #(
  parameter int WIDTH   = 3,
  parameter int DIV_W   = 24,
  parameter int DIV_MAX = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left_req,
  input  logic             right_req,
  input  logic             hazard_req,
  output logic [WIDTH-1:0] lamp_l,
  output logic [WIDTH-1:0] lamp_r,
  output logic             busy,
  output logic             done
);
  import light_seq_ctrl_pkg::*;

  if (WIDTH < 2 || WIDTH > 31) begin : g_bad_width
    $error("light_seq_ctrl: WIDTH must be in 2..31");
  end

  localparam int                STEP_W     = $clog2(WIDTH + 1);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(WIDTH);
  localparam logic [WIDTH-1:0]  LAMP_FIRST = WIDTH'(1);
  localparam logic [WIDTH-1:0]  LAMP_ALL   = '1;

  state_t            r_state;
  logic [STEP_W-1:0] r_step;     // sweep: lit lamp count (0 = off phase); hazard: 1 = on phase
  logic [WIDTH-1:0]  r_lamp_l;
  logic [WIDTH-1:0]  r_lamp_r;
  logic              r_busy;
  logic              r_done;

  logic              w_haz;
  logic              w_sweep;
  logic              w_preempt;
  logic              w_tick;
  logic              w_clr;
  logic              w_en;
  logic [WIDTH-1:0]  w_therm_next;

  // Both directions at once is treated as a hazard request.
  assign w_haz        = hazard_req || (left_req && right_req);
  assign w_sweep      = (r_state == ST_LEFT) || (r_state == ST_RIGHT);
  assign w_preempt    = w_sweep && w_haz;
  assign w_en         = (r_state != ST_IDLE);
  // Prescaler restarts from 0 whenever a phase starts fresh: held in IDLE and on preemption.
  assign w_clr        = (r_state == ST_IDLE) || w_preempt;
  assign w_therm_next = WIDTH'(thermo(int'(r_step) + 1));

  tick_gen #(
    .DIV_W   (DIV_W),
    .DIV_MAX (DIV_MAX)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_step   <= '0;
      r_lamp_l <= '0;
      r_lamp_r <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_haz) begin
            r_state  <= ST_HAZ;
            r_step   <= STEP_W'(1);
            r_lamp_l <= LAMP_ALL;
            r_lamp_r <= LAMP_ALL;
            r_busy   <= 1'b1;
          end else if (left_req) begin
            r_state  <= ST_LEFT;
            r_step   <= STEP_W'(1);
            r_lamp_l <= LAMP_FIRST;
            r_lamp_r <= '0;
            r_busy   <= 1'b1;
          end else if (right_req) begin
            r_state  <= ST_RIGHT;
            r_step   <= STEP_W'(1);
            r_lamp_l <= '0;
            r_lamp_r <= LAMP_FIRST;
            r_busy   <= 1'b1;
          end
        end

        ST_LEFT, ST_RIGHT: begin
          if (w_preempt) begin
            r_state  <= ST_HAZ;
            r_step   <= STEP_W'(1);
            r_lamp_l <= LAMP_ALL;
            r_lamp_r <= LAMP_ALL;
          end else if (w_tick) begin
            if (r_step == '0) begin
              // End of off phase: sweep complete.
              r_state  <= ST_IDLE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_lamp_l <= '0;
              r_lamp_r <= '0;
            end else if (r_step == STEP_LAST) begin
              r_step   <= '0;
              r_lamp_l <= '0;
              r_lamp_r <= '0;
            end else begin
              r_step <= r_step + 1'b1;
              if (r_state == ST_LEFT) r_lamp_l <= w_therm_next;
              else                    r_lamp_r <= w_therm_next;
            end
          end
        end

        ST_HAZ: begin
          if (w_tick) begin
            if (r_step != '0) begin
              r_step   <= '0;
              r_lamp_l <= '0;
              r_lamp_r <= '0;
            end else if (!w_haz) begin
              // Only leave from the off phase so the lamps are never left lit.
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_step   <= STEP_W'(1);
              r_lamp_l <= LAMP_ALL;
              r_lamp_r <= LAMP_ALL;
            end
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_step   <= '0;
          r_lamp_l <= '0;
          r_lamp_r <= '0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign lamp_l = r_lamp_l;
  assign lamp_r = r_lamp_r;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_light_seq_ctrl.sv
// Purpose: scoreboard bench for light_seq_ctrl (WIDTH=3/DIV_MAX=1 and WIDTH=5/DIV_MAX=0).
// Latency: expectations are queued per cycle at the negedge and checked after the posedge.
// Backpressure: n/a.
module tb_light_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       l3, r3, h3, l5, r5, h5;
  logic [2:0] lamp_l3, lamp_r3;
  logic [4:0] lamp_l5, lamp_r5;
  logic       busy3, done3, busy5, done5;

  light_seq_ctrl #(.WIDTH(3), .DIV_W(24), .DIV_MAX(1)) u_dut3 (
    .clk(clk), .reset(reset), .left_req(l3), .right_req(r3), .hazard_req(h3),
    .lamp_l(lamp_l3), .lamp_r(lamp_r3), .busy(busy3), .done(done3)
  );

  light_seq_ctrl #(.WIDTH(5), .DIV_W(8), .DIV_MAX(0)) u_dut5 (
    .clk(clk), .reset(reset), .left_req(l5), .right_req(r5), .hazard_req(h5),
    .lamp_l(lamp_l5), .lamp_r(lamp_r5), .busy(busy5), .done(done5)
  );

  typedef struct packed {
    logic       sel;   // 0 = 3-lamp instance, 1 = 5-lamp instance
    logic [4:0] el;
    logic [4:0] er;
    logic       eb;
    logic       ed;
    logic [7:0] tn;
    logic [7:0] cn;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_no  = 0;

  // Expected bank patterns, indexed by cycle after the request is applied.
  logic [4:0] sw3  [10] = '{5'd1, 5'd1, 5'd3, 5'd3, 5'd7, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0};
  logic [4:0] haz3 [10] = '{5'd7, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0};
  logic [4:0] t5l  [9]  = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0};
  logic [4:0] t5r  [9]  = '{5'd1, 5'd1, 5'd3, 5'd7, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0};
  logic [4:0] t6l  [8]  = '{5'd1, 5'd3, 5'd7, 5'd15, 5'd31, 5'd0, 5'd0, 5'd0};

  // Apply inputs for the next edge and queue the outputs expected after it.
  task automatic drive(input logic sel, input logic rst, input logic l, input logic r,
                       input logic h, input logic [4:0] el, input logic [4:0] er,
                       input logic eb, input logic ed, input int tn);
    exp_t e;
    @(negedge clk);
    reset = rst;
    l3 = sel ? 1'b0 : l;  r3 = sel ? 1'b0 : r;  h3 = sel ? 1'b0 : h;
    l5 = sel ? l : 1'b0;  r5 = sel ? r : 1'b0;  h5 = sel ? h : 1'b0;
    e.sel = sel; e.el = el; e.er = er; e.eb = eb; e.ed = ed;
    e.tn = 8'(tn); e.cn = 8'(cyc_no);
    cyc_no++;
    sb_q.push_back(e);
  endtask

  // Monitor: checks one queued expectation per cycle, just after the active edge.
  initial begin
    exp_t       e;
    logic [4:0] al, ar;
    logic       ab, ad;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e  = sb_q.pop_front();
        al = e.sel ? lamp_l5 : {2'b00, lamp_l3};
        ar = e.sel ? lamp_r5 : {2'b00, lamp_r3};
        ab = e.sel ? busy5 : busy3;
        ad = e.sel ? done5 : done3;
        n_tests++;
        if (al !== e.el || ar !== e.er || ab !== e.eb || ad !== e.ed) begin
          n_fail++;
          $display("FAIL t%0d c%0d: got l=%b r=%b busy=%b done=%b, want l=%b r=%b busy=%b done=%b",
                   e.tn, e.cn, al, ar, ab, ad, e.el, e.er, e.eb, e.ed);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    l3 = 1'b0; r3 = 1'b0; h3 = 1'b0;
    l5 = 1'b0; r5 = 1'b0; h5 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, then idle after release.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 0);

    // Left sweep from a 1-clk request; a right request mid-sweep is ignored.
    for (int i = 0; i < 10; i++)
      drive(1'b0, 1'b0, i == 0, (i == 2 || i == 3), 1'b0,
            sw3[i], 5'd0, i < 8, i == 8, 2);

    // Left+right together -> hazard blink; drop after two on phases.
    for (int i = 0; i < 10; i++)
      drive(1'b0, 1'b0, i < 6, i < 6, 1'b0,
            haz3[i], haz3[i], i < 8, i == 8, 3);

    // Right held: two sweeps with a single IDLE cycle between them.
    for (int i = 0; i < 19; i++) begin
      if (i < 9)
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, sw3[i], i < 8, i == 8, 4);
      else
        drive(1'b0, 1'b0, 1'b0, i < 10, 1'b0, 5'd0, sw3[i-9], (i - 9) < 8, (i - 9) == 8, 4);
    end

    // Hazard preempts a right sweep at step 2, no done on the abort.
    for (int i = 0; i < 9; i++)
      drive(1'b0, 1'b0, 1'b0, i == 0, i == 3,
            t5l[i], t5r[i], i < 7, i == 7, 5);

    // Asynchronous reset mid left sweep.
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, i == 0, 1'b0, 1'b0, sw3[i], 5'd0, 1'b1, 1'b0, 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1);

    // Five-lamp bank, step every clk.
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b0, i == 0, 1'b0, 1'b0, t6l[i], 5'd0, i < 6, i == 6, 6);

    repeat (3) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
